mult_sched: RTL and testbench
=============================

# mult_sched

Controller and two-port arbiter for the shared shift-add multiplier datapath. It grants the single multiplier to one of two requesters in round-robin order and drives the operand select. It then sequences the datapath load, add and shift strobes for an N-bit multiplication and pulses a per-requester done. It sits between the requesting units and the multiplier datapath (Q/A registers, adder), replacing a fixed-length hard-wired sequencer.

## Interface
- N, default 4: multiplier operand width; number of add/shift iterations; legal 2..16.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- req  in  2  per-requester request; level, held high until the matching done.
- q0  in  1  LSB of the datapath Q register, valid during ADD cycles.
- gnt  out  2  one-hot grant; high from LOAD through DONE inclusive.
- sel  out  1  operand mux select to datapath (index of the granted requester).
- CargaQ  out  1  load the Q register with the selected multiplier operand.
- ResetA  out  1  clear the A accumulator.
- CargaA  out  1  load A with A+M (add step).
- DesplazaQ  out  1  shift the A:Q pair right one bit.
- done  out  2  one-cycle pulse to the served requester; result valid on the datapath that cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE. Iteration counter cnt, width $clog2(N+1).
- IDLE: if any req is high, latch the winner into an owner register, go to LOAD. Otherwise stay.
- Arbitration: round-robin with a last-served pointer lp. If both requests are high, the requester != lp wins. A single request wins regardless of lp. lp updates to the owner in DONE.
- LOAD: CargaQ=1, ResetA=1, cnt<=0, go to ADD.
- ADD: CargaA = q0, go to SHIFT.
- SHIFT: DesplazaQ=1, cnt<=cnt+1. If cnt==N-1, go to DONE; otherwise go to ADD.
- DONE: done[owner]=1 for one cycle, go to IDLE.
- gnt[owner] and sel=owner stay constant from LOAD through DONE. Both are 0 in IDLE.
- A req deasserted mid-operation does not abort the operation. The sequence completes and done still pulses.
- A req high in DONE is not granted in DONE. It is evaluated in the following IDLE cycle.
- Strobes are mutually exclusive except CargaQ+ResetA, which are both high in LOAD.

## Timing
- Reset values: state=IDLE, cnt=0, lp=1 (requester 0 wins the first tie), owner=0. All outputs are 0.
- A reset asserted in any state takes effect at the next edge. State goes to IDLE and no done is issued. Outputs are 0 the cycle after.
- Latency: req seen in IDLE at cycle 0, LOAD at cycle 1, ADD/SHIFT pairs at cycles 2..2N+1, DONE at cycle 2N+2. For N=4, done is at cycle 10.
- Back-to-back: after DONE there is one mandatory IDLE cycle. Throughput is one operation per 2N+3 cycles.
- Outputs are Moore-decoded from state and owner, except CargaA, which is state ADD AND q0 (combinational on q0).

## Structure
- Package mult_pkg: state enum (IDLE, LOAD, ADD, SHIFT, DONE, 3-bit encoding) and the default width constant MULT_N=4.
- One sub-module: rr_arb2 (2-input round-robin, inputs req[1:0] and lp, output one-hot winner). It is combinational, and the pointer register lives in mult_sched.
- Counter, owner register and FSM are in the top level.

## Test plan
- Single request, N=4: req=2'b01 from cycle 0, q0 sequence 1,1,0,1 (multiplier 4'b1011). Expect:
  - LOAD at cycle 1.
  - CargaA high at cycles 2, 4, 8, and low at cycle 6.
  - DesplazaQ high at cycles 3, 5, 7, 9.
  - done=2'b01 at cycle 10 only.
  - gnt=2'b01 over cycles 1..10.
- Tie after reset: req=2'b11 at cycle 0. Expect requester 0 served first (done=01 at cycle 10), IDLE at cycle 11, requester 1 granted (LOAD at 12), done=10 at cycle 21.
- Fairness: hold req=2'b11 continuously for 4 operations. Expect grants alternating 0,1,0,1, with no requester served twice in a row.
- Request withdrawn: req0 high for cycles 0..3 only. Expect the sequence to complete anyway, with done=01 at cycle 10, busy high over 1..10, and no second grant.
- Reset mid-operation: assert reset at cycle 5 during requester 1's operation. Expect all outputs 0 from cycle 6, no done, and lp back to 1. A subsequent tie is won by requester 0.
- Width check: N=2 with q0 held 1. Expect CargaA at cycles 2 and 4, DesplazaQ at cycles 3 and 5, done at cycle 6.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier scheduler.
//   MULT_N  : default operand width / iteration count
//   state_e : controller state encoding (3 bits)
package mult_pkg;

    localparam int unsigned MULT_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
//   req : per-requester request
//   lp  : index of the last-served requester (pointer kept by the caller)
//   win : one-hot winner, all-zero when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       lp,
    output logic [1:0] win
);

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = lp ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Arbiter and sequencer for the shared shift-add multiplier datapath.
//   clk, reset : clock, synchronous active-high reset
//   req        : per-requester level request, held until its done
//   q0         : Q register LSB, consulted in ADD
//   gnt, sel   : one-hot grant and operand select for the current owner
//   CargaQ, ResetA, CargaA, DesplazaQ : datapath strobes
//   done       : one-cycle completion pulse to the owner
//   busy       : controller not idle
module mult_sched
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       q0,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       CargaQ,
    output logic       ResetA,
    output logic       CargaA,
    output logic       DesplazaQ,
    output logic [1:0] done,
    output logic       busy
);

    localparam int unsigned CW = $clog2(N + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          lp_q, lp_d;
    logic [1:0]    win;
    logic [1:0]    owner_oh;

    rr_arb2 u_arb (
        .req (req),
        .lp  (lp_q),
        .win (win)
    );

    // State, counter, owner and last-served pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            lp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            lp_q    <= lp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        lp_d    = lp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = win[1];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(N - 1)) ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                lp_d    = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore decode from state and owner; CargaA additionally follows q0 directly.
    always_comb begin
        owner_oh  = owner_q ? 2'b10 : 2'b01;
        busy      = (state_q != ST_IDLE);
        gnt       = busy ? owner_oh : 2'b00;
        sel       = busy & owner_q;
        CargaQ    = (state_q == ST_LOAD);
        ResetA    = (state_q == ST_LOAD);
        CargaA    = (state_q == ST_ADD) & q0;
        DesplazaQ = (state_q == ST_SHIFT);
        done      = (state_q == ST_DONE) ? owner_oh : 2'b00;
    end

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: one N=4 instance and one N=2 instance.
module tb_mult_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic       q0;
    logic [1:0] gnt;
    logic       sel;
    logic       CargaQ;
    logic       ResetA;
    logic       CargaA;
    logic       DesplazaQ;
    logic [1:0] done;
    logic       busy;

    logic [1:0] req2;
    logic       q02;
    logic [1:0] gnt2;
    logic       sel2;
    logic       CargaQ2;
    logic       ResetA2;
    logic       CargaA2;
    logic       DesplazaQ2;
    logic [1:0] done2;
    logic       busy2;

    int checks;
    int errors;

    mult_sched #(.N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .q0        (q0),
        .gnt       (gnt),
        .sel       (sel),
        .CargaQ    (CargaQ),
        .ResetA    (ResetA),
        .CargaA    (CargaA),
        .DesplazaQ (DesplazaQ),
        .done      (done),
        .busy      (busy)
    );

    mult_sched #(.N(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req2),
        .q0        (q02),
        .gnt       (gnt2),
        .sel       (sel2),
        .CargaQ    (CargaQ2),
        .ResetA    (ResetA2),
        .CargaA    (CargaA2),
        .DesplazaQ (DesplazaQ2),
        .done      (done2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector layout: {gnt[1:0], sel, CargaQ, ResetA, CargaA, DesplazaQ, done[1:0], busy}
    function automatic logic [9:0] act_vec();
        return {gnt, sel, CargaQ, ResetA, CargaA, DesplazaQ, done, busy};
    endfunction

    function automatic logic [9:0] act_vec2();
        return {gnt2, sel2, CargaQ2, ResetA2, CargaA2, DesplazaQ2, done2, busy2};
    endfunction

    // Expected outputs at cycle c of an operation (req first seen in IDLE at c=0).
    function automatic logic [9:0] exp_vec(int c, logic own, logic q0v, int n);
        logic [9:0] v;
        logic [1:0] oh;
        v  = '0;
        oh = own ? 2'b10 : 2'b01;
        if (c >= 1 && c <= 2 * n + 2) begin
            v[9:8] = oh;
            v[7]   = own;
            v[0]   = 1'b1;
            if (c == 1) begin
                v[6] = 1'b1;
                v[5] = 1'b1;
            end else if (c <= 2 * n + 1) begin
                if (c % 2 == 0) v[4] = q0v;
                else            v[3] = 1'b1;
            end else begin
                v[2:1] = oh;
            end
        end
        return v;
    endfunction

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] a;
        reset = 1'b1; req = 2'b11; q0 = 1'b1; req2 = 2'b11; q02 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = act_vec();
        checks++;
        if (a !== 10'b0) begin errors++; $display("FAIL reset_n4 act=%b exp=%b", a, 10'b0); end
        a = act_vec2();
        checks++;
        if (a !== 10'b0) begin errors++; $display("FAIL reset_n2 act=%b exp=%b", a, 10'b0); end
        @(posedge clk); #1;
        req = 2'b00; req2 = 2'b00;
        reset = 1'b0;
        @(negedge clk);
        a = act_vec();
        checks++;
        if (a !== 10'b0) begin errors++; $display("FAIL reset_release act=%b exp=%b", a, 10'b0); end
    endtask

    task automatic test_single();
        logic [3:0] seq;
        logic [9:0] a, e;
        seq = 4'b1011;
        for (int c = 0; c <= 12; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0)  req = 2'b01;
            if (c == 11) req = 2'b00;
            q0 = (c >= 2 && c <= 8 && c % 2 == 0) ? seq[(c - 2) / 2] : 1'b1;
            if (c == 0) #1; else @(negedge clk);
            a = act_vec();
            e = exp_vec(c, 1'b0, q0, 4);
            checks++;
            if (a !== e) begin errors++; $display("FAIL single c=%0d act=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_tie();
        logic [9:0] a, e;
        pulse_reset();
        for (int c = 0; c <= 23; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0)  req = 2'b11;
            if (c == 22) req = 2'b00;
            q0 = ((c % 3) == 0);
            if (c == 0) #1; else @(negedge clk);
            a = act_vec();
            e = (c <= 10) ? exp_vec(c, 1'b0, q0, 4) : exp_vec(c - 11, 1'b1, q0, 4);
            checks++;
            if (a !== e) begin errors++; $display("FAIL tie c=%0d act=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_fairness();
        logic [9:0] a, e;
        for (int c = 0; c <= 45; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0)  req = 2'b11;
            if (c == 44) req = 2'b00;
            q0 = ((c % 5) < 2);
            if (c == 0) #1; else @(negedge clk);
            a = act_vec();
            e = (c >= 44) ? 10'b0 : exp_vec(c % 11, 1'((c / 11) % 2), q0, 4);
            checks++;
            if (a !== e) begin errors++; $display("FAIL fairness c=%0d act=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_withdraw();
        logic [9:0] a, e;
        for (int c = 0; c <= 14; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0) req = 2'b01;
            if (c == 4) req = 2'b00;
            q0 = (c % 4 == 2);
            if (c == 0) #1; else @(negedge clk);
            a = act_vec();
            e = exp_vec(c, 1'b0, q0, 4);
            checks++;
            if (a !== e) begin errors++; $display("FAIL withdraw c=%0d act=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] a, e;
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0) req = 2'b10;
            if (c == 5) begin reset = 1'b1; req = 2'b00; end
            if (c == 6) reset = 1'b0;
            q0 = 1'b1;
            if (c == 0) #1; else @(negedge clk);
            a = act_vec();
            e = (c <= 5) ? exp_vec(c, 1'b1, q0, 4) : 10'b0;
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_mid c=%0d act=%b exp=%b", c, a, e); end
        end
        // Pointer must be back at 1, so requester 0 wins the next tie.
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0)  req = 2'b11;
            if (c == 11) req = 2'b00;
            q0 = (c % 4 == 0);
            if (c == 0) #1; else @(negedge clk);
            a = act_vec();
            e = exp_vec(c, 1'b0, q0, 4);
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_tie c=%0d act=%b exp=%b", c, a, e); end
        end
    endtask

    task automatic test_width_n2();
        logic [9:0] a, e;
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) @(negedge clk); else begin @(posedge clk); #1; end
            if (c == 0) req2 = 2'b10;
            if (c == 7) req2 = 2'b00;
            q02 = 1'b1;
            if (c == 0) #1; else @(negedge clk);
            a = act_vec2();
            e = exp_vec(c, 1'b1, 1'b1, 2);
            checks++;
            if (a !== e) begin errors++; $display("FAIL width_n2 c=%0d act=%b exp=%b", c, a, e); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 2'b00;
        q0     = 1'b0;
        req2   = 2'b00;
        q02    = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_withdraw();
        test_reset_mid();
        test_width_n2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
